// File: rtl/vec_pkg.sv
// Shared types and memory map for the vector unit RUN sequencer.
// Word memory: A at 1..16, B at 17..32, result nibbles at 33/34.
package vec_pkg;

    localparam int WORD_BITS = 4;
    localparam int MAX_LEN   = 16;
    localparam int ADDR_BITS = 6;
    localparam int LEN_BITS  = 5;
    localparam int ACC_BITS  = 8;

    localparam logic [ADDR_BITS-1:0] INSTRUCT_OFFSET = 6'd0;
    localparam logic [ADDR_BITS-1:0] A_BASE          = 6'd1;
    localparam logic [ADDR_BITS-1:0] B_BASE          = 6'd17;
    localparam logic [ADDR_BITS-1:0] OUT_BASE        = 6'd33;

    localparam logic [1:0] OP_DOT     = 2'd0;
    localparam logic [1:0] OP_SUM     = 2'd1;
    localparam logic [1:0] OP_HAMM    = 2'd2;
    localparam logic [1:0] OP_ILLEGAL = 2'd3;

    localparam logic [1:0] STATUS_IDLE = 2'd0;
    localparam logic [1:0] STATUS_BUSY = 2'd1;
    localparam logic [1:0] STATUS_DONE = 2'd2;
    localparam logic [1:0] STATUS_ERR  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_DRAIN = 3'd2,
        S_WR_LO = 3'd3,
        S_WR_HI = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_e;

    function automatic logic [1:0] status_of(input state_e s);
        case (s)
            S_IDLE:  return STATUS_IDLE;
            S_DONE:  return STATUS_DONE;
            S_ERR:   return STATUS_ERR;
            default: return STATUS_BUSY;
        endcase
    endfunction

endpackage

// File: rtl/vec_reduce_alu.sv
// Combinational per-element reduction term f(a,b,op), zero-extended to 8 bits.
module vec_reduce_alu
    import vec_pkg::*;
(
    input  logic [WORD_BITS-1:0] a,
    input  logic [WORD_BITS-1:0] b,
    input  logic [1:0]           op,
    output logic [ACC_BITS-1:0]  f
);

    always_comb begin
        f = '0;
        case (op)
            OP_DOT:  f = {4'b0, a} * {4'b0, b};
            OP_SUM:  f = {4'b0, a} + {4'b0, b};
            OP_HAMM: f = {7'b0, (a != b)};
            default: f = '0;
        endcase
    end

endmodule

// File: rtl/vector_run_sequencer.sv
// RUN opcode sequencer: streams A/B element pairs through the reduce ALU into an
// 8-bit accumulator, then writes the result as two nibbles at OUT_BASE/OUT_BASE+1.
module vector_run_sequencer
    import vec_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [3:0]           instr,
    input  logic [LEN_BITS-1:0]  len,
    output logic                 mem_req,
    input  logic                 mem_gnt,
    output logic [ADDR_BITS-1:0] rd_addr_a,
    output logic [ADDR_BITS-1:0] rd_addr_b,
    input  logic [WORD_BITS-1:0] rd_data_a,
    input  logic [WORD_BITS-1:0] rd_data_b,
    output logic                 wr_en,
    output logic [ADDR_BITS-1:0] wr_addr,
    output logic [WORD_BITS-1:0] wr_data,
    output logic [1:0]           status,
    output logic [ACC_BITS-1:0]  result,
    output state_e               dbg_state
);

    // Handshake: a memory access takes place in exactly the cycles where
    // mem_req && mem_gnt; read data returns on rd_data_* one cycle later.

    state_e               state_q, state_d;
    logic [LEN_BITS-1:0]  idx_q, idx_d;
    logic [LEN_BITS-1:0]  len_q, len_d;
    logic [1:0]           op_q, op_d;
    logic [ACC_BITS-1:0]  acc_q, acc_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [ACC_BITS-1:0]  f_val;
    logic                 can_start;

    vec_reduce_alu u_alu (
        .a  (rd_data_a),
        .b  (rd_data_b),
        .op (op_q),
        .f  (f_val)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            len_q      <= '0;
            op_q       <= OP_DOT;
            acc_q      <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            op_q       <= op_d;
            acc_q      <= acc_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign can_start = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        len_d      = len_q;
        op_d       = op_q;
        acc_d      = acc_q;
        rd_valid_d = (state_q == S_RUN) && mem_gnt;
        if (rd_valid_q) begin
            acc_d = acc_q + f_val;
        end
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (can_start) begin
                    if (instr[1:0] == OP_ILLEGAL || len > LEN_BITS'(MAX_LEN)) begin
                        state_d = S_ERR;
                    end else begin
                        acc_d   = '0;
                        idx_d   = '0;
                        len_d   = len;
                        op_d    = instr[1:0];
                        state_d = (len == '0) ? S_WR_LO : S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (mem_gnt) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == len_q - 1'b1) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            // The last granted read lands during DRAIN and is folded in here.
            S_DRAIN: state_d = S_WR_LO;
            S_WR_LO: if (mem_gnt) state_d = S_WR_HI;
            S_WR_HI: if (mem_gnt) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        rd_addr_a = '0;
        rd_addr_b = '0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        case (state_q)
            S_RUN: begin
                mem_req   = 1'b1;
                rd_addr_a = A_BASE + {1'b0, idx_q};
                rd_addr_b = B_BASE + {1'b0, idx_q};
            end
            S_WR_LO: begin
                mem_req = 1'b1;
                wr_en   = 1'b1;
                wr_addr = OUT_BASE;
                wr_data = acc_q[3:0];
            end
            S_WR_HI: begin
                mem_req = 1'b1;
                wr_en   = 1'b1;
                wr_addr = OUT_BASE + 6'd1;
                wr_data = acc_q[7:4];
            end
            default: ;
        endcase
    end

    assign status    = status_of(state_q);
    assign result    = acc_q;
    assign dbg_state = state_q;

endmodule
